// File: rtl/level_column_gen_if.sv
// Sample and column handshake bundle for the audio level-to-column generator.
// The DUT uses the slave modport and the sample source/column consumer uses master.
interface level_column_gen_if #(
  parameter int SAMPLE_W   = 24,
  parameter int COL_H      = 100,
  parameter int NUM_LEVELS = 16,
  parameter int LED_W      = 10
);
  localparam int LVL_W = $clog2(NUM_LEVELS + 1);

  logic signed [SAMPLE_W-1:0] audio_left;
  logic signed [SAMPLE_W-1:0] audio_right;
  logic                       read;
  logic [1:0]                 mode;
  logic                       seen;
  logic [COL_H-1:0]           next_frame;
  logic                       frame_valid;
  logic [LVL_W-1:0]           level;
  logic [LED_W-1:0]           LEDR;
  logic [7:0]                 overrun_cnt;

  modport master (
    output audio_left, audio_right, read, mode, seen,
    input  next_frame, frame_valid, level, LEDR, overrun_cnt
  );

  modport slave (
    input  audio_left, audio_right, read, mode, seen,
    output next_frame, frame_valid, level, LEDR, overrun_cnt
  );
endinterface

// File: rtl/level_column_gen.sv
// Reduces each window of audio sample pairs to a level, then presents a centred
// column bitmap and LED thermometer until the column consumer acknowledges it.
module level_column_gen #(
  parameter int SAMPLE_W   = 24,
  parameter int WINDOW     = 2200,
  parameter int COL_H      = 100,
  parameter int NUM_LEVELS = 16,
  parameter int BAR_STEP   = 2,
  parameter int AVG_STEP   = 300000 * WINDOW / 4260,
  parameter int PEAK_STEP  = 400000,
  parameter int LED_W      = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  level_column_gen_if.slave     bus
);
  localparam int ACC_W  = SAMPLE_W + 1 + $clog2(WINDOW);
  localparam int CNT_W  = $clog2(WINDOW + 1);
  localparam int LVL_W  = $clog2(NUM_LEVELS + 1);
  localparam int CENTRE = COL_H / 2;

  localparam logic [1:0] ST_ACCUM   = 2'd0;
  localparam logic [1:0] ST_SCAN    = 2'd1;
  localparam logic [1:0] ST_PRESENT = 2'd2;

  localparam logic [ACC_W-1:0] AVG_STEP_A  = ACC_W'(AVG_STEP);
  localparam logic [ACC_W-1:0] PEAK_STEP_A = ACC_W'(PEAK_STEP);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [ACC_W-1:0] metric_q, metric_d;
  logic [ACC_W-1:0] thresh_q, thresh_d;
  logic [LVL_W-1:0] k_q, k_d;
  logic [1:0]       mode_q, mode_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [COL_H-1:0] next_frame_q, next_frame_d;
  logic             frame_valid_q, frame_valid_d;
  logic [LED_W-1:0] ledr_q, ledr_d;
  logic [7:0]       overrun_q, overrun_d;

  logic [SAMPLE_W-1:0] abs_l, abs_r, peak_abs;
  logic [ACC_W-1:0]    peak_pick;
  logic [ACC_W-1:0]    step_scan;
  logic [1:0]          mode_eff;
  logic                scan_done;
  logic [LVL_W-1:0]    scan_level;

  // The most-negative code has no positive twin, so it clips to full scale.
  function automatic logic [SAMPLE_W-1:0] abs_sat(input logic signed [SAMPLE_W-1:0] x);
    abs_sat = x;
    if (x[SAMPLE_W-1]) begin
      if (x == {1'b1, {(SAMPLE_W-1){1'b0}}})
        abs_sat = {1'b0, {(SAMPLE_W-1){1'b1}}};
      else
        abs_sat = -x;
    end
  endfunction

  function automatic logic [COL_H-1:0] column_bitmap(input logic [LVL_W-1:0] lvl);
    int half;
    column_bitmap = '0;
    half = int'(lvl) * BAR_STEP;
    for (int i = 0; i < COL_H; i++)
      column_bitmap[i] = (i >= CENTRE - half) && (i < CENTRE + half);
  endfunction

  function automatic logic [LED_W-1:0] thermometer(input logic [LVL_W-1:0] lvl);
    thermometer = '0;
    for (int i = 0; i < LED_W; i++)
      thermometer[i] = (int'(lvl) > i);
  endfunction

  always_comb begin
    abs_l     = abs_sat(bus.audio_left);
    abs_r     = abs_sat(bus.audio_right);
    peak_abs  = (abs_l > abs_r) ? abs_l : abs_r;
    peak_pick = ACC_W'(peak_abs);
    mode_eff  = (count_q == '0) ? bus.mode : mode_q;
    step_scan = (mode_q == 2'b11) ? PEAK_STEP_A : AVG_STEP_A;
  end

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    metric_d      = metric_q;
    thresh_d      = thresh_q;
    k_d           = k_q;
    mode_d        = mode_q;
    level_d       = level_q;
    next_frame_d  = next_frame_q;
    frame_valid_d = frame_valid_q;
    ledr_d        = ledr_q;
    overrun_d     = overrun_q;
    scan_done     = 1'b0;
    scan_level    = '0;

    case (state_q)
      ST_ACCUM: begin
        if (bus.read) begin
          mode_d  = mode_eff;
          count_d = count_q + CNT_W'(1);
          case (mode_eff)
            2'b00:   metric_d = metric_q + ACC_W'(abs_l) + ACC_W'(abs_r);
            2'b01:   metric_d = metric_q + ACC_W'(abs_l);
            2'b10:   metric_d = metric_q + ACC_W'(abs_r);
            default: metric_d = (metric_q > peak_pick) ? metric_q : peak_pick;
          endcase
          if (count_d == CNT_W'(WINDOW)) begin
            state_d  = ST_SCAN;
            k_d      = LVL_W'(1);
            thresh_d = (mode_eff == 2'b11) ? PEAK_STEP_A : AVG_STEP_A;
          end
        end
      end

      // Threshold k*STEP is built by repeated addition, one level per cycle.
      ST_SCAN: begin
        if (metric_q > thresh_q) begin
          if (k_q == LVL_W'(NUM_LEVELS)) begin
            scan_done  = 1'b1;
            scan_level = k_q;
          end else begin
            k_d      = k_q + LVL_W'(1);
            thresh_d = thresh_q + step_scan;
          end
        end else begin
          scan_done  = 1'b1;
          scan_level = k_q - LVL_W'(1);
        end
        if (scan_done) begin
          state_d       = ST_PRESENT;
          level_d       = scan_level;
          next_frame_d  = column_bitmap(scan_level);
          ledr_d        = thermometer(scan_level);
          frame_valid_d = 1'b1;
        end
      end

      ST_PRESENT: begin
        if (bus.seen && frame_valid_q) begin
          state_d       = ST_ACCUM;
          frame_valid_d = 1'b0;
          count_d       = '0;
          metric_d      = '0;
        end
      end

      default: state_d = ST_ACCUM;
    endcase

    // Samples arriving while the window is closed are lost; count them.
    if (bus.read && (state_q != ST_ACCUM) && (overrun_q != 8'hFF))
      overrun_d = overrun_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_ACCUM;
      count_q       <= '0;
      metric_q      <= '0;
      thresh_q      <= '0;
      k_q           <= '0;
      mode_q        <= 2'b00;
      level_q       <= '0;
      next_frame_q  <= '0;
      frame_valid_q <= 1'b0;
      ledr_q        <= '0;
      overrun_q     <= '0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      metric_q      <= metric_d;
      thresh_q      <= thresh_d;
      k_q           <= k_d;
      mode_q        <= mode_d;
      level_q       <= level_d;
      next_frame_q  <= next_frame_d;
      frame_valid_q <= frame_valid_d;
      ledr_q        <= ledr_d;
      overrun_q     <= overrun_d;
    end
  end

  assign bus.next_frame  = next_frame_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.level       = level_q;
  assign bus.LEDR        = ledr_q;
  assign bus.overrun_cnt = overrun_q;
endmodule
